// File: rtl/jtpopeye_obj_pkg.sv
// jtpopeye_obj_pkg: shared types and widths for the object DMA sequencer.
package jtpopeye_obj_pkg;
    localparam int OBJ_AW = 10;
    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, DONE} state_t;
endpackage

// File: rtl/jtpopeye_edge_cen.sv
// jtpopeye_edge_cen: rising-edge detector whose history register only advances on cen.
module jtpopeye_edge_cen (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic din,
    output logic rise
);
    logic dl;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dl <= 1'b0;
        else if (cen) dl <= din;
    assign rise = din & ~dl;
endmodule

// File: rtl/jtpopeye_obj_dma.sv
// jtpopeye_obj_dma: copies LEN bytes of main RAM into the object buffer on each VB rise.
// Define JTPOPEYE_DMA_DBLBUF_EN to toggle obj_bank after every completed transfer.
module jtpopeye_obj_dma
    import jtpopeye_obj_pkg::*;
#(
    parameter int LEN   = 1024,
    parameter int START = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cen,
    input  logic              VB,
    input  logic              busak_n,
    output logic              busrq_n,
    output logic              dma_cs,
    output logic [OBJ_AW-1:0] AD_DMA,
    input  logic [7:0]        DD_DMA,
    output logic              obj_we,
    output logic [OBJ_AW-1:0] obj_addr,
    output logic [7:0]        obj_data,
    output logic              obj_bank,
    output logic              busy
);
    localparam logic [OBJ_AW-1:0] ST   = OBJ_AW'(START);
    localparam logic [OBJ_AW-1:0] LAST = OBJ_AW'(LEN - 1);

    state_t state, nxt;
    logic start;
    logic [OBJ_AW-1:0] cnt;
    logic [7:0] lat;

    jtpopeye_edge_cen u_vb (
        .clk  (clk),
        .rst_n(rst_n),
        .cen  (cpu_cen),
        .din  (VB),
        .rise (start)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else if (cpu_cen) state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? REQ : IDLE;
            REQ:     nxt = !busak_n ? XFER : !VB ? IDLE : REQ;
            XFER:    nxt = (!busak_n && cnt == LAST) ? DRAIN : XFER;
            DRAIN:   nxt = !busak_n ? DONE : DRAIN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = state != IDLE;
        busrq_n = ~busy;
        dma_cs  = state == XFER || state == DRAIN;
    end

    // lat holds the byte read in the previous active cycle, so a lost grant simply stalls the pipe
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            AD_DMA   <= ST;
            cnt      <= '0;
            lat      <= '0;
            obj_we   <= 1'b0;
            obj_addr <= '0;
            obj_data <= '0;
        end else begin
            obj_we <= 1'b0;
            if (cpu_cen && !busak_n) begin
                if (state == REQ) begin
                    AD_DMA <= ST;
                    cnt    <= '0;
                end
                if (state == XFER) begin
                    AD_DMA <= AD_DMA + 1'b1;
                    cnt    <= cnt + 1'b1;
                    lat    <= DD_DMA;
                    if (cnt != '0) begin
                        obj_we   <= 1'b1;
                        obj_addr <= cnt - 1'b1;
                        obj_data <= lat;
                    end
                end
                if (state == DRAIN) begin
                    obj_we   <= 1'b1;
                    obj_addr <= LAST;
                    obj_data <= lat;
                end
            end
        end

`ifdef JTPOPEYE_DMA_DBLBUF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) obj_bank <= 1'b0;
        else if (cpu_cen && state == DONE) obj_bank <= ~obj_bank;
`else
    assign obj_bank = 1'b0;
`endif
endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// tb_jtpopeye_obj_dma: directed and randomized checks of the object DMA against a transfer-level model.
module tb_jtpopeye_obj_dma;
    localparam int LEN   = 1024;
    localparam int START = 0;
    localparam int NONE  = 1 << 20;

    logic clk = 0, rst_n = 0, cpu_cen = 0, VB = 0, busak_n = 1;
    logic busrq_n, dma_cs, obj_we, obj_bank, busy;
    logic [9:0] AD_DMA, obj_addr;
    logic [7:0] DD_DMA, obj_data;
    logic [7:0] ram [1024];
    int total = 0, bad = 0, we_clks = 0, tot_wr = 0, exp_bank = 0;
    int wa[$];
    int wd[$];

    jtpopeye_obj_dma #(.LEN(LEN), .START(START)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_cen (cpu_cen),
        .VB      (VB),
        .busak_n (busak_n),
        .busrq_n (busrq_n),
        .dma_cs  (dma_cs),
        .AD_DMA  (AD_DMA),
        .DD_DMA  (DD_DMA),
        .obj_we  (obj_we),
        .obj_addr(obj_addr),
        .obj_data(obj_data),
        .obj_bank(obj_bank),
        .busy    (busy)
    );

    assign DD_DMA = ram[AD_DMA];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (obj_we) we_clks++;
        cpu_cen = ~cpu_cen;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        do @(posedge clk); while (!cpu_cen);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a completed transfer writes ram[(START+i)%1024] to obj_addr i for i=0..LEN-1 and
    // holds the bus LEN+2 cen after the grant, plus any cen spent with the grant withdrawn.
    task automatic xfer(input int gd, input int pat, input int pl, input int v2, input int stop_at);
        int hold, errs, last_bank;
        logic p;
        wa.delete();
        wd.delete();
        VB = 1;
        tick();
        chk("req_busrq", busrq_n, 0);
        repeat (gd) tick();
        chk("wait_no_cs", dma_cs, 0);
        busak_n = 0;
        tick();
        chk("grant_cs", dma_cs, 1);
        chk("grant_ad", AD_DMA, START % 1024);
        hold = 0;
        last_bank = -1;
        errs = 0;
        while (busrq_n === 1'b0 && hold < LEN + 100) begin
            p = busak_n;
            tick();
            hold++;
            if (obj_we) begin
                wa.push_back(int'(obj_addr));
                wd.push_back(int'(obj_data));
                if (p) errs++;
                if (obj_addr == 10'(LEN - 1)) last_bank = int'(obj_bank);
            end
            if (hold == pat) busak_n = 1;
            if (hold == pat + pl) busak_n = 0;
            if (hold == v2) VB = 0;
            if (hold == v2 + 3) VB = 1;
            if (wa.size() == stop_at) begin
                tot_wr += wa.size();
                return;
            end
        end
        tot_wr += wa.size();
        chk("we_in_pause", errs, 0);
        chk("hold_cens", hold, LEN + 2 + pl);
        chk("n_writes", wa.size(), LEN);
        errs = 0;
        foreach (wa[i]) if (wa[i] != i || wd[i] != int'(ram[(START + i) % 1024])) errs++;
        chk("write_seq", errs, 0);
        chk("busy_end", busy, 0);
        chk("bank_at_last_wr", last_bank, exp_bank);
`ifdef JTPOPEYE_DMA_DBLBUF_EN
        exp_bank ^= 1;
`endif
        chk("bank_after", obj_bank, exp_bank);
        tick();
        chk("no_requeue", busrq_n, 1);
        VB = 0;
        busak_n = 1;
        repeat (3) tick();
    endtask

    initial begin
        int nwe;
        #3;
        chk("rst_busrq", busrq_n, 1);
        chk("rst_cs", dma_cs, 0);
        chk("rst_we", obj_we, 0);
        chk("rst_ad", AD_DMA, START % 1024);
        chk("rst_oaddr", obj_addr, 0);
        chk("rst_odata", obj_data, 0);
        chk("rst_bank", obj_bank, 0);
        chk("rst_busy", busy, 0);
        #9 rst_n = 1;
        repeat (3) tick();

        foreach (ram[i]) ram[i] = 8'(i) ^ 8'h5A;
        xfer(3, NONE, 0, NONE, NONE);

        VB = 1;
        tick();
        chk("abort_req", busrq_n, 0);
        chk("abort_busy", busy, 1);
        nwe = 0;
        repeat (20) begin
            tick();
            if (obj_we || dma_cs) nwe++;
        end
        VB = 0;
        tick();
        chk("abort_rel", busrq_n, 1);
        chk("abort_busy0", busy, 0);
        chk("abort_nwe", nwe, 0);
        chk("abort_bank", obj_bank, exp_bank);
        repeat (3) tick();

        foreach (ram[i]) ram[i] = 8'($urandom);
        xfer(int'($urandom_range(1, 6)), 100, 5, NONE, NONE);

        foreach (ram[i]) ram[i] = 8'($urandom);
        xfer(int'($urandom_range(1, 6)), NONE, 0, 200, NONE);

        foreach (ram[i]) ram[i] = 8'($urandom);
        xfer(int'($urandom_range(1, 6)), int'($urandom_range(3, 1000)), int'($urandom_range(1, 9)), NONE, NONE);

        foreach (ram[i]) ram[i] = 8'($urandom);
        xfer(2, NONE, 0, NONE, 501);
        chk("pre_rst_we", obj_we, 1);
        #6 rst_n = 0;
        VB = 0;
        busak_n = 1;
        #1;
        chk("mid_rst_busrq", busrq_n, 1);
        chk("mid_rst_cs", dma_cs, 0);
        chk("mid_rst_we", obj_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ad", AD_DMA, START % 1024);
        chk("mid_rst_bank", obj_bank, 0);
        exp_bank = 0;
        #5 rst_n = 1;
        repeat (3) tick();

        foreach (ram[i]) ram[i] = 8'($urandom);
        xfer(int'($urandom_range(1, 6)), NONE, 0, NONE, NONE);

        chk("we_pulse_width", we_clks, tot_wr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
